crumb_compare_sequencer: RTL and testbench

Multi-cycle magnitude comparator that sits directly downstream of the 2-bit `crumb_comparator`. It consumes one crumb-comparison result per accepted cycle, most-significant crumb first, and accumulates them into a single greater/equal/less verdict for an operand of NUM_CRUMBS×2 bits. Wide operands can then be compared with one 2-bit comparator that is time-shared, so the comparator does not need to be replicated.

---
 rtl/crumb_compare_sequencer_pkg.sv | 15 +
 rtl/crumb_flag_decode.sv | 20 ++
 rtl/crumb_compare_sequencer.sv | 126 ++++++++++++
 tb/tb_crumb_compare_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/crumb_compare_sequencer_pkg.sv
// Shared definitions for the crumb compare sequencer: FSM state encoding and
// the one-hot flag-triple constants in {f1,f2,f3} bit order.
package crumb_compare_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [2:0] FLAG_GT = 3'b100;
  localparam logic [2:0] FLAG_EQ = 3'b010;
  localparam logic [2:0] FLAG_LT = 3'b001;

endpackage

// File: rtl/crumb_flag_decode.sv
// Combinational decode of one crumb_comparator flag triple into its verdict,
// flagging any triple that is not exactly one-hot.
module crumb_flag_decode
  import crumb_compare_sequencer_pkg::*;
(
  input  logic [2:0] flags,
  output logic       is_gt,
  output logic       is_eq,
  output logic       is_lt,
  output logic       bad_flags
);

  always_comb begin
    is_gt     = (flags == FLAG_GT);
    is_eq     = (flags == FLAG_EQ);
    is_lt     = (flags == FLAG_LT);
    bad_flags = !(is_gt || is_eq || is_lt);
  end

endmodule

// File: rtl/crumb_compare_sequencer.sv
// Accumulates per-crumb compare flags, MSB crumb first, into one wide
// greater/equal/less verdict using a time-shared 2-bit comparator.
module crumb_compare_sequencer
  import crumb_compare_sequencer_pkg::*;
#(
  parameter int NUM_CRUMBS = 4,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             f1,
  input  logic             f2,
  input  logic             f3,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic             err,
  output logic [CNT_W-1:0] crumb_cnt
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CRUMBS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             err_q, err_d;
  logic             decided_q, decided_d;
  logic             pend_gt_q, pend_gt_d;

  logic is_gt, is_eq, is_lt, bad_flags;

  crumb_flag_decode u_decode (
    .flags     ({f1, f2, f3}),
    .is_gt     (is_gt),
    .is_eq     (is_eq),
    .is_lt     (is_lt),
    .bad_flags (bad_flags)
  );

  // The decision is held privately in decided/pend_gt so gt/lt stay low
  // while busy and only appear together with the done pulse.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gt_d      = gt_q;
    eq_d      = eq_q;
    lt_d      = lt_q;
    err_d     = err_q;
    decided_d = decided_q;
    pend_gt_d = pend_gt_q;

    if (start) begin
      state_d   = ST_RUN;
      cnt_d     = '0;
      gt_d      = 1'b0;
      eq_d      = 1'b0;
      lt_d      = 1'b0;
      err_d     = 1'b0;
      decided_d = 1'b0;
      pend_gt_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_RUN: begin
          if (in_valid) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (bad_flags) begin
              err_d = 1'b1;
            end
            if (!decided_q && !is_eq && !bad_flags) begin
              decided_d = 1'b1;
              pend_gt_d = is_gt;
            end
            if (cnt_q == LAST_CNT) begin
              state_d = ST_DONE;
              gt_d    = decided_d && pend_gt_d;
              lt_d    = decided_d && !pend_gt_d && (decided_q || is_lt);
              eq_d    = !decided_d;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      gt_q      <= 1'b0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
      err_q     <= 1'b0;
      decided_q <= 1'b0;
      pend_gt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gt_q      <= gt_d;
      eq_q      <= eq_d;
      lt_q      <= lt_d;
      err_q     <= err_d;
      decided_q <= decided_d;
      pend_gt_q <= pend_gt_d;
    end
  end

  always_comb begin
    busy      = (state_q == ST_RUN);
    done      = (state_q == ST_DONE);
    gt        = gt_q;
    eq        = eq_q;
    lt        = lt_q;
    err       = err_q;
    crumb_cnt = cnt_q;
  end

endmodule

// File: tb/tb_crumb_compare_sequencer.sv
// Self-checking bench: a queue-based model of accepted crumbs is compared with
// the DUT every cycle, plus literal expectations for the directed scenarios.
module tb_crumb_compare_sequencer;

  localparam int N  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [2:0]    flags = 3'b010;
  logic          busy, done, gt, eq, lt, err;
  logic [CW-1:0] crumb_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int done_count = 0;
  time t_start;

  crumb_compare_sequencer #(.NUM_CRUMBS(N), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .f1        (flags[2]),
    .f2        (flags[1]),
    .f3        (flags[0]),
    .busy      (busy),
    .done      (done),
    .gt        (gt),
    .eq        (eq),
    .lt        (lt),
    .err       (err),
    .crumb_cnt (crumb_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: remembers the accepted crumbs of the current comparison
  // and derives the verdict from the first legal non-equal crumb.
  bit         model_live = 1'b0;
  bit         m_run = 1'b0;
  bit         m_done = 1'b0;
  bit         m_gt = 1'b0, m_eq = 1'b0, m_lt = 1'b0, m_err = 1'b0;
  logic [2:0] m_q[$];

  function automatic logic [2:0] verdictOf(input logic [2:0] q[$]);
    foreach (q[i]) begin
      if (q[i] == 3'b100) return 3'b100;
      if (q[i] == 3'b001) return 3'b001;
    end
    return 3'b010;
  endfunction

  function automatic logic [2:0] crumbFlags(input logic [7:0] a, input logic [7:0] b, input int i);
    logic [1:0] ca, cb;
    ca = 2'(a >> (6 - 2 * i));
    cb = 2'(b >> (6 - 2 * i));
    if (ca > cb) return 3'b100;
    if (ca == cb) return 3'b010;
    return 3'b001;
  endfunction

  always @(posedge clk) begin
    logic [2:0] v;
    model_live = 1'b1;
    if (rst) begin
      m_run = 0; m_done = 0; m_gt = 0; m_eq = 0; m_lt = 0; m_err = 0;
      m_q.delete();
    end else if (start) begin
      m_run = 1; m_done = 0; m_gt = 0; m_eq = 0; m_lt = 0; m_err = 0;
      m_q.delete();
    end else if (m_done) begin
      m_done = 0;
    end else if (m_run && in_valid) begin
      m_q.push_back(flags);
      if (!(flags inside {3'b100, 3'b010, 3'b001})) m_err = 1;
      if (m_q.size() == N) begin
        v = verdictOf(m_q);
        {m_gt, m_eq, m_lt} = v;
        m_run = 0;
        m_done = 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [9:0] expv, actv;
    if (model_live) begin
      expv = {m_run, m_done, m_gt, m_eq, m_lt, m_err, CW'(m_q.size())};
      actv = {busy, done, gt, eq, lt, err, crumb_cnt};
      n_cmp++;
      if (actv !== expv) begin
        n_bad++;
        $display("[TB] FAIL model_cycle @%0t: got {busy,done,gt,eq,lt,err,cnt}=%b required %b", $time, actv, expv);
      end
    end
    if (done === 1'b1) done_count++;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, expv);
    end
  endtask

  task automatic startCmp(input bit with_valid, input logic [2:0] f);
    @(posedge clk); #2;
    start = 1'b1; in_valid = with_valid; flags = f;
    @(posedge clk);
    t_start = $time;
    #2;
    start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [2:0] f);
    in_valid = 1'b1; flags = f;
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic bubble();
    @(posedge clk); #2;
  endtask

  task automatic waitDone(output int lat);
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = int'(($time - t_start + 5) / 10);
        break;
      end
    end
    if (lat < 0) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int lat;
    int d0;

    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_state", {busy, done, gt, eq, lt, err, crumb_cnt}, 32'd0);

    // B4 vs B1: crumbs EQ,EQ,GT,LT -> greater
    startCmp(1'b0, 3'b010);
    for (int i = 0; i < 4; i++) applyStimulus(crumbFlags(8'hB4, 8'hB1, i));
    waitDone(lat);
    checkOutput("t1_latency", lat, 5);
    checkOutput("t1_verdict", {gt, eq, lt, err}, 4'b1000);
    checkOutput("t1_cnt", crumb_cnt, 4);

    // 5A vs 5A with a bubble after crumb 2
    startCmp(1'b0, 3'b010);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(crumbFlags(8'h5A, 8'h5A, i));
      if (i == 1) bubble();
    end
    waitDone(lat);
    checkOutput("t2_latency", lat, 6);
    checkOutput("t2_verdict", {gt, eq, lt, err}, 4'b0100);

    // 3F vs C0: LT decides, later GT crumbs ignored
    startCmp(1'b0, 3'b010);
    for (int i = 0; i < 4; i++) applyStimulus(crumbFlags(8'h3F, 8'hC0, i));
    waitDone(lat);
    checkOutput("t3_latency", lat, 5);
    checkOutput("t3_verdict", {gt, eq, lt, err}, 4'b0010);

    // Illegal second crumb, rest EQ
    startCmp(1'b0, 3'b010);
    applyStimulus(3'b010);
    applyStimulus(3'b110);
    applyStimulus(3'b010);
    applyStimulus(3'b010);
    waitDone(lat);
    checkOutput("t4_verdict", {gt, eq, lt, err}, 4'b0101);

    // Abort after two crumbs; restart carries an in_valid that must be ignored
    startCmp(1'b0, 3'b010);
    applyStimulus(3'b001);
    applyStimulus(3'b001);
    #1 d0 = done_count; #0;
    startCmp(1'b1, 3'b100);
    checkOutput("t5_restart_cnt", {busy, crumb_cnt}, {1'b1, 4'd0});
    for (int i = 0; i < 4; i++) applyStimulus(3'b100);
    waitDone(lat);
    #1;
    checkOutput("t5_single_done", done_count - d0, 1);
    checkOutput("t5_latency", lat, 5);
    checkOutput("t5_verdict", {gt, eq, lt, err}, 4'b1000);

    // Reset mid-run after three crumbs
    startCmp(1'b0, 3'b010);
    for (int i = 0; i < 3; i++) applyStimulus(3'b100);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    checkOutput("t6_after_reset", {busy, done, gt, eq, lt, err, crumb_cnt}, 32'd0);
    d0 = done_count;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("t6_no_done", done_count - d0, 0);

    startCmp(1'b0, 3'b010);
    for (int i = 0; i < 4; i++) applyStimulus(crumbFlags(8'h3F, 8'hC0, i));
    waitDone(lat);
    checkOutput("t6_restart_latency", lat, 5);
    checkOutput("t6_restart_verdict", {gt, eq, lt, err, crumb_cnt}, {4'b0010, 4'd4});

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
